// File: rtl/uart_bus_bridge.sv
// UART debug bridge: receives framed 'W'/'R' commands on rx_in, runs one memory-bus
// transaction per command as a bus initiator, and answers with 'K' (+ read data) or 'E'.
module uart_bus_bridge #(
    parameter logic [15:0] CLK_DIV       = 16'd103,
    parameter logic [31:0] FRAME_TIMEOUT = 32'd100000,
    parameter logic [15:0] BUS_TIMEOUT   = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_in,
    output logic        tx_out,
    output logic [31:0] address_out,
    output logic        sel_out,
    output logic        read_out,
    input  logic [31:0] read_value_in,
    output logic [3:0]  write_mask_out,
    output logic [31:0] write_value_out,
    input  logic        ready_in,
    output logic        busy_out
);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS, P_RESP} p_state_t;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;

    logic        rx_meta_q, rx_sync_q;
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        byte_valid_s, frame_err_s;

    p_state_t    p_state_q, p_state_d;
    logic        is_read_q, is_read_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        sel_q, sel_d, read_q, read_d, busy_q, busy_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] frame_tmr_q, frame_tmr_d;
    logic [15:0] bus_tmr_q, bus_tmr_d;
    logic [31:0] resp_buf_q, resp_buf_d;
    logic [2:0]  resp_left_q, resp_left_d;

    logic [9:0]  tx_shift_q, tx_shift_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]  tx_bits_q, tx_bits_d;
    logic        tx_load_s, tx_done_s;
    logic [7:0]  tx_byte_s;

    // Two-flop synchronizer on the asynchronous serial input.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver: mid-bit sampling of start, 8 data bits and stop.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_cnt_d   = {1'b0, CLK_DIV[15:1]};
                    rx_state_d = RX_START;
                end else begin
                    rx_cnt_d   = 16'd0;
                end
            end
            RX_START, RX_DATA, RX_STOP: begin
                if (rx_cnt_q != 16'd0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else begin
                    rx_cnt_d = CLK_DIV;
                    case (rx_state_q)
                        RX_START: begin
                            rx_bit_d   = 3'd0;
                            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                        end
                        RX_DATA: begin
                            rx_byte_d  = {rx_sync_q, rx_byte_q[7:1]};
                            rx_bit_d   = rx_bit_q + 3'd1;
                            rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
                        end
                        default: begin
                            byte_valid_s = rx_sync_q;
                            frame_err_s  = !rx_sync_q;
                            rx_state_d   = RX_IDLE;
                        end
                    endcase
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Parser / bus master / response sequencer.
    always_comb begin
        p_state_d   = p_state_q;
        is_read_d   = is_read_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        read_d      = read_q;
        mask_d      = mask_q;
        busy_d      = busy_q;
        frame_tmr_d = 32'd0;
        bus_tmr_d   = bus_tmr_q;
        resp_buf_d  = resp_buf_q;
        resp_left_d = resp_left_q;
        tx_load_s   = 1'b0;
        tx_byte_s   = 8'h00;
        case (p_state_q)
            P_IDLE: begin
                byte_cnt_d = 2'd0;
                if (byte_valid_s && (rx_byte_q == OP_WRITE || rx_byte_q == OP_READ)) begin
                    is_read_d = (rx_byte_q == OP_READ);
                    busy_d    = 1'b1;
                    p_state_d = P_ADDR;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            P_ADDR, P_DATA: begin
                if (frame_err_s) begin
                    busy_d    = 1'b0;
                    p_state_d = P_IDLE;
                end else if (byte_valid_s) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (p_state_q == P_ADDR) begin
                        addr_d  = {rx_byte_q, addr_q[31:8]};
                    end else begin
                        wdata_d = {rx_byte_q, wdata_q[31:8]};
                    end
                    if (byte_cnt_q != 2'd3) begin
                        p_state_d = p_state_q;
                    end else if (p_state_q == P_ADDR && !is_read_q) begin
                        p_state_d = P_DATA;
                    end else begin
                        p_state_d = P_BUS;
                        sel_d     = 1'b1;
                        read_d    = is_read_q;
                        mask_d    = is_read_q ? 4'h0 : 4'hF;
                        bus_tmr_d = 16'd0;
                    end
                end else if (frame_tmr_q >= FRAME_TIMEOUT - 32'd1) begin
                    busy_d    = 1'b0;
                    p_state_d = P_IDLE;
                end else begin
                    frame_tmr_d = frame_tmr_q + 32'd1;
                end
            end
            P_BUS: begin
                // ready_in takes priority over a coincident timeout
                if (ready_in || bus_tmr_q >= BUS_TIMEOUT - 16'd1) begin
                    sel_d       = 1'b0;
                    read_d      = 1'b0;
                    mask_d      = 4'h0;
                    p_state_d   = P_RESP;
                    tx_load_s   = 1'b1;
                    tx_byte_s   = ready_in ? RSP_OK : RSP_ERR;
                    resp_buf_d  = read_value_in;
                    resp_left_d = (ready_in && is_read_q) ? 3'd4 : 3'd0;
                end else begin
                    bus_tmr_d   = bus_tmr_q + 16'd1;
                end
            end
            P_RESP: begin
                if (tx_done_s && resp_left_q != 3'd0) begin
                    tx_load_s   = 1'b1;
                    tx_byte_s   = resp_buf_q[7:0];
                    resp_buf_d  = {8'h00, resp_buf_q[31:8]};
                    resp_left_d = resp_left_q - 3'd1;
                end else if (tx_done_s) begin
                    busy_d      = 1'b0;
                    p_state_d   = P_IDLE;
                end else begin
                    p_state_d   = P_RESP;
                end
            end
            default: begin
                sel_d     = 1'b0;
                read_d    = 1'b0;
                mask_d    = 4'h0;
                busy_d    = 1'b0;
                p_state_d = P_IDLE;
            end
        endcase
    end

    // Transmitter: the last stop-bit clock is where the next byte gets loaded.
    assign tx_done_s = (tx_bits_q == 4'd1) && (tx_cnt_q == 16'd0);

    // Transmit shift register {stop, data, start}, shifted right once per bit period.
    always_comb begin
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bits_d  = tx_bits_q;
        if (tx_load_s) begin
            tx_shift_d = {1'b1, tx_byte_s, 1'b0};
            tx_cnt_d   = CLK_DIV;
            tx_bits_d  = 4'd10;
        end else if (tx_bits_q == 4'd0) begin
            tx_shift_d = 10'h3FF;
        end else if (tx_cnt_q != 16'd0) begin
            tx_cnt_d   = tx_cnt_q - 16'd1;
        end else begin
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_cnt_d   = CLK_DIV;
            tx_bits_d  = tx_bits_q - 4'd1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= 16'd0;
            rx_bit_q    <= 3'd0;
            rx_byte_q   <= 8'h00;
            p_state_q   <= P_IDLE;
            is_read_q   <= 1'b0;
            byte_cnt_q  <= 2'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            sel_q       <= 1'b0;
            read_q      <= 1'b0;
            mask_q      <= 4'h0;
            busy_q      <= 1'b0;
            frame_tmr_q <= 32'd0;
            bus_tmr_q   <= 16'd0;
            resp_buf_q  <= 32'h0;
            resp_left_q <= 3'd0;
            tx_shift_q  <= 10'h3FF;
            tx_cnt_q    <= 16'd0;
            tx_bits_q   <= 4'd0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_byte_q   <= rx_byte_d;
            p_state_q   <= p_state_d;
            is_read_q   <= is_read_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            read_q      <= read_d;
            mask_q      <= mask_d;
            busy_q      <= busy_d;
            frame_tmr_q <= frame_tmr_d;
            bus_tmr_q   <= bus_tmr_d;
            resp_buf_q  <= resp_buf_d;
            resp_left_q <= resp_left_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bits_q   <= tx_bits_d;
        end
    end

    assign tx_out          = tx_shift_q[0];
    assign address_out     = addr_q;
    assign write_value_out = wdata_q;
    assign sel_out         = sel_q;
    assign read_out        = read_q;
    assign write_mask_out  = mask_q;
    assign busy_out        = busy_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: drives UART commands, answers the bus, and
// decodes the UART response into a byte queue checked against hand-computed values.
module tb_uart_bus_bridge;

    logic        clk, reset, rx_in, tx_out, sel_out, read_out, ready_in, busy_out;
    logic [31:0] address_out, read_value_in, write_value_out;
    logic [3:0]  write_mask_out;

    int          n_assert = 0;
    int          n_fail = 0;
    int          sel_total = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  cmd_q[$];
    int          sel_len, unstable, sel_base;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_mask;
    logic        cap_read;
    int          tx_phase = 0;
    int          tx_stop_err = 0;
    logic        tx_mon_busy = 1'b0;
    logic [7:0]  tx_sh = 8'h00;

    uart_bus_bridge #(
        .CLK_DIV(16'd3), .FRAME_TIMEOUT(32'd200), .BUS_TIMEOUT(16'd16)
    ) dut (
        .clk(clk), .reset(reset), .rx_in(rx_in), .tx_out(tx_out),
        .address_out(address_out), .sel_out(sel_out), .read_out(read_out),
        .read_value_in(read_value_in), .write_mask_out(write_mask_out),
        .write_value_out(write_value_out), .ready_in(ready_in), .busy_out(busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Counts bus cycles and decodes tx_out (bit period 4 clocks) into tx_q.
    always @(negedge clk) begin
        if (sel_out === 1'b1) sel_total++;
        if (!tx_mon_busy) begin
            if (tx_out === 1'b0) begin
                tx_mon_busy = 1'b1;
                tx_phase = 0;
            end
        end else begin
            tx_phase++;
            if (tx_phase >= 6 && tx_phase <= 34 && (tx_phase % 4) == 2)
                tx_sh = {tx_out, tx_sh[7:1]};
            if (tx_phase == 38) begin
                if (tx_out !== 1'b1) tx_stop_err++;
                tx_q.push_back(tx_sh);
                tx_mon_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (4) @(negedge clk);
        end
        rx_in = stop;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic send_cmd();
        for (int i = 0; i < cmd_q.size(); i++) uart_send(cmd_q[i], 1'b1);
    endtask

    // Waits for sel_out, raises ready_in on sel cycle ready_at (0 = never).
    task automatic serve(input int ready_at);
        int w;
        int n;
        w = 0;
        n = 0;
        unstable = 0;
        while (sel_out !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        cap_addr  = address_out;
        cap_wdata = write_value_out;
        cap_mask  = write_mask_out;
        cap_read  = read_out;
        while (sel_out === 1'b1 && n < 100) begin
            n++;
            if (address_out !== cap_addr || write_value_out !== cap_wdata ||
                write_mask_out !== cap_mask || read_out !== cap_read) unstable++;
            ready_in = (n == ready_at);
            @(negedge clk);
        end
        ready_in = 1'b0;
        sel_len = n;
    endtask

    task automatic wait_tx(input string tag, input int n);
        int w;
        w = 0;
        while (tx_q.size() < n && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 32'(tx_q.size()), 32'(n));
    endtask

    task automatic chk_tx(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        if (tx_q.size() > 0) b = tx_q.pop_front();
        else b = 8'hxx;
        chk(tag, {24'h0, b}, {24'h0, exp});
    endtask

    initial begin
        reset = 1'b1;
        rx_in = 1'b1;
        ready_in = 1'b0;
        read_value_in = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_out), 32'd1);
        chk("rst_sel", 32'(sel_out), 32'd0);
        chk("rst_read", 32'(read_out), 32'd0);
        chk("rst_mask", 32'(write_mask_out), 32'd0);
        chk("rst_addr", address_out, 32'h0);
        chk("rst_wdata", write_value_out, 32'h0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Write 0xDEADBEEF to 0x10, ready on the 2nd sel cycle
        cmd_q = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        fork
            send_cmd();
            serve(2);
        join
        chk("wr_sel_len", 32'(sel_len), 32'd2);
        chk("wr_addr", cap_addr, 32'h10);
        chk("wr_wdata", cap_wdata, 32'hDEADBEEF);
        chk("wr_mask", 32'(cap_mask), 32'hF);
        chk("wr_read", 32'(cap_read), 32'd0);
        chk("wr_stable", 32'(unstable), 32'd0);
        wait_tx("wr_tx_count", 1);
        chk_tx("wr_ack", 8'h4B);
        repeat (3) @(negedge clk);
        chk("wr_busy_end", 32'(busy_out), 32'd0);

        // Read 0x4, ready in the 1st sel cycle
        read_value_in = 32'h12345678;
        cmd_q = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h00};
        fork
            send_cmd();
            serve(1);
        join
        chk("rd_sel_len", 32'(sel_len), 32'd1);
        chk("rd_addr", cap_addr, 32'h4);
        chk("rd_read", 32'(cap_read), 32'd1);
        chk("rd_mask", 32'(cap_mask), 32'h0);
        chk("rd_read_drop", 32'(read_out), 32'd0);
        wait_tx("rd_tx_count", 5);
        chk_tx("rd_ack", 8'h4B);
        chk_tx("rd_b0", 8'h78);
        chk_tx("rd_b1", 8'h56);
        chk_tx("rd_b2", 8'h34);
        chk_tx("rd_b3", 8'h12);
        repeat (3) @(negedge clk);
        chk("rd_busy_end", 32'(busy_out), 32'd0);

        // Bus timeout: ready never comes
        cmd_q = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h00};
        fork
            send_cmd();
            serve(0);
        join
        chk("to_sel_len", 32'(sel_len), 32'd16);
        wait_tx("to_tx_count", 1);
        chk("to_busy_stop", 32'(busy_out), 32'd1);
        chk_tx("to_err", 8'h45);
        repeat (2) @(negedge clk);
        chk("to_busy_end", 32'(busy_out), 32'd0);

        // Junk bytes are ignored
        sel_base = sel_total;
        uart_send(8'h00, 1'b1);
        uart_send(8'hFF, 1'b1);
        repeat (60) @(negedge clk);
        chk("junk_tx", 32'(tx_q.size()), 32'd0);
        chk("junk_sel", 32'(sel_total - sel_base), 32'd0);
        chk("junk_busy", 32'(busy_out), 32'd0);

        // 'W' with a low stop bit is dropped; a following read still works
        uart_send(8'h57, 1'b0);
        repeat (20) @(negedge clk);
        chk("ferr_busy", 32'(busy_out), 32'd0);
        read_value_in = 32'hA5A55A5A;
        cmd_q = '{8'h52, 8'h0C, 8'h00, 8'h00, 8'h00};
        fork
            send_cmd();
            serve(3);
        join
        chk("ferr_sel_len", 32'(sel_len), 32'd3);
        chk("ferr_addr", cap_addr, 32'hC);
        chk("ferr_read", 32'(cap_read), 32'd1);
        wait_tx("ferr_tx_count", 5);
        chk_tx("ferr_ack", 8'h4B);
        chk_tx("ferr_b0", 8'h5A);
        chk_tx("ferr_b1", 8'h5A);
        chk_tx("ferr_b2", 8'hA5);
        chk_tx("ferr_b3", 8'hA5);

        // Frame timeout between address bytes
        repeat (10) @(negedge clk);
        sel_base = sel_total;
        uart_send(8'h57, 1'b1);
        uart_send(8'h01, 1'b1);
        chk("ft_busy_mid", 32'(busy_out), 32'd1);
        repeat (250) @(negedge clk);
        chk("ft_busy_abort", 32'(busy_out), 32'd0);
        uart_send(8'h00, 1'b1);
        uart_send(8'h00, 1'b1);
        uart_send(8'h00, 1'b1);
        repeat (60) @(negedge clk);
        chk("ft_sel", 32'(sel_total - sel_base), 32'd0);
        chk("ft_tx", 32'(tx_q.size()), 32'd0);
        chk("ft_busy_end", 32'(busy_out), 32'd0);
        chk("tx_stop_bits", 32'(tx_stop_err), 32'd0);

        // Reset while collecting write data
        cmd_q = '{8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'h11};
        send_cmd();
        reset = 1'b1;
        @(negedge clk);
        chk("rdata_tx", 32'(tx_out), 32'd1);
        chk("rdata_sel", 32'(sel_out), 32'd0);
        chk("rdata_busy", 32'(busy_out), 32'd0);
        chk("rdata_addr", address_out, 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        cmd_q = '{8'h57, 8'h30, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
        fork
            send_cmd();
            serve(1);
        join
        chk("rw1_sel_len", 32'(sel_len), 32'd1);
        chk("rw1_addr", cap_addr, 32'h30);
        chk("rw1_wdata", cap_wdata, 32'h01020304);
        chk("rw1_mask", 32'(cap_mask), 32'hF);
        wait_tx("rw1_tx_count", 1);
        chk_tx("rw1_ack", 8'h4B);
        repeat (5) @(negedge clk);

        // Reset while the read response is being sent
        read_value_in = 32'hCAFEF00D;
        cmd_q = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h00};
        fork
            send_cmd();
            serve(1);
        join
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rresp_tx", 32'(tx_out), 32'd1);
        chk("rresp_sel", 32'(sel_out), 32'd0);
        chk("rresp_busy", 32'(busy_out), 32'd0);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        tx_q.delete();
        cmd_q = '{8'h57, 8'h50, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        fork
            send_cmd();
            serve(2);
        join
        chk("rw2_sel_len", 32'(sel_len), 32'd2);
        chk("rw2_addr", cap_addr, 32'h50);
        chk("rw2_wdata", cap_wdata, 32'h12345678);
        chk("rw2_stable", 32'(unstable), 32'd0);
        wait_tx("rw2_tx_count", 1);
        chk_tx("rw2_ack", 8'h4B);
        repeat (3) @(negedge clk);
        chk("rw2_busy_end", 32'(busy_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

Serial-to-memory-bus debug bridge: a UART command receiver that acts as an initiator on the core's memory bus, the opposite end of the bus that memory-mapped peripherals such as the UART respond on. A host sends framed read/write commands over `rx_in`. The block issues one bus transaction per command and returns an acknowledge and read data on `tx_out`. It sits beside the CPU as a second bus master, arbitrated externally, for program loading and memory inspection.

## Interface
- `CLK_DIV`, 16'd103: bit period is `CLK_DIV+1` clocks; same convention as the UART `clk_div` register.
- `FRAME_TIMEOUT`, 32'd100000: maximum idle clocks between bytes of one command before the frame is aborted.
- `BUS_TIMEOUT`, 16'd1024: maximum clocks that `sel_out` may be held without `ready_in`.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_in` in 1: serial input, 8N1, LSB first, idle high.
- `tx_out` out 1: serial output, 8N1, LSB first, idle high.
- `address_out` out 32: bus address (byte address).
- `sel_out` out 1: bus request.
- `read_out` out 1: read strobe.
- `read_value_in` in 32: read data, valid in a cycle where `ready_in` is high.
- `write_mask_out` out 4: byte write enables.
- `write_value_out` out 32: write data.
- `ready_in` in 1: transaction complete.
- `busy_out` out 1: high from the first accepted command byte until the last response stop bit ends.

## Operation
- **Receiver**
  - The receiver is idle while `rx_in` is high. A low sample loads a counter with `CLK_DIV>>1` and starts a frame.
  - The start bit is re-checked at mid-bit. If `rx_in` is high there, the frame is a glitch and the receiver returns to idle.
  - 8 data bits are then sampled every `CLK_DIV+1` clocks, followed by the stop bit.
  - Stop bit high: `byte_valid` pulses for 1 cycle at the stop-bit sample.
  - Stop bit low: framing error. The byte is discarded and the parser aborts to IDLE.
- **Parser FSM** (states IDLE, ADDR, DATA, BUS, RESP)
  - IDLE: 0x57 ('W') or 0x52 ('R') latches the opcode and moves to ADDR. Any other byte is ignored.
  - ADDR: collects 4 bytes, little-endian, into `address_out`. W goes to DATA; R goes to BUS.
  - DATA: collects 4 bytes, little-endian, into `write_value_out`, then goes to BUS.
  - The inter-byte timer resets on every `byte_valid` in ADDR/DATA. Reaching `FRAME_TIMEOUT` returns the FSM to IDLE with no response and no bus access.
  - BUS: `sel_out`=1.
    - Write: `read_out`=0, `write_mask_out`=4'b1111.
    - Read: `read_out`=1, `write_mask_out`=0.
    - `address_out`, `write_value_out`, `read_out` and `write_mask_out` are held stable until completion.
    - On a cycle with `ready_in`=1, `read_value_in` is captured into a response buffer. Next cycle `sel_out`, `read_out` and `write_mask_out` are 0, and the FSM moves to RESP.
    - If `BUS_TIMEOUT` clocks elapse without `ready_in`, the bus is dropped the same way and the response is the error byte.
  - RESP: transmits the queued response bytes, then returns to IDLE.
    - Write OK: 0x4B ('K').
    - Read OK: 0x4B, then data bytes [7:0], [15:8], [23:16], [31:24].
    - Timeout: 0x45 ('E').
  - Bytes received in BUS or RESP are discarded.
- **Transmitter**
  - Uses a 10-bit shift register {1, data, 0}, shifting right every `CLK_DIV+1` clocks; `tx_out` = bit 0.
  - Response bytes are sent back-to-back: the next start bit follows immediately after the previous stop bit.

## Timing
- Reset values: `tx_out`=1, `sel_out`=0, `read_out`=0, `write_mask_out`=0, `address_out`=0, `write_value_out`=0, `busy_out`=0.
  - The FSM goes to IDLE, the receiver to idle, and the timers to 0.
- Reset asserted mid-frame or mid-transaction takes effect at the next edge.
  - Outputs take their reset values.
  - A `tx_out` byte in progress is truncated.
- `sel_out` rises 1 clock after the `byte_valid` of the last command byte.
- Minimum bus transaction: 1 cycle, when `ready_in` is already high in the first `sel_out` cycle.
- The first response start bit goes out 1 clock after the transaction completes.
- Each byte takes 10×(`CLK_DIV+1`) clocks.
- `ready_in` is ignored while `sel_out`=0.
- `ready_in` and the timeout in the same cycle: `ready_in` wins.
- The bus timer counts from 0 in the first `sel_out` cycle. The timeout fires in the cycle the count equals `BUS_TIMEOUT-1` without `ready_in`.

## Test plan
Bench parameters: `CLK_DIV`=3, `BUS_TIMEOUT`=16, `FRAME_TIMEOUT`=200.

1. **Write:** send 57 10 00 00 00 EF BE AD DE, with `ready_in` raised on the 2nd `sel_out` cycle.
   - Expect one write: `address_out`=0x10, `write_value_out`=0xDEADBEEF, mask 4'hF.
   - Expect `tx_out` to carry 0x4B.
2. **Read:** send 52 04 00 00 00, with `read_value_in`=0x12345678 and `ready_in` on the 1st cycle.
   - Expect `read_out`=1, `address_out`=4, `sel_out` high for exactly 1 cycle.
   - Expect tx bytes 4B 78 56 34 12.
3. **Bus timeout:** read with `ready_in` held 0.
   - Expect `sel_out` high for exactly 16 cycles, then tx byte 0x45.
   - Expect `busy_out` to fall after the stop bit.
4. **Junk and framing:** send 0x00 and 0xFF.
   - Expect no response and `busy_out`=0.
   - Then send 57 with a low stop bit: expect the parser to stay in IDLE. A following valid 52 command completes normally.
5. **Frame timeout:** send 57 01, then idle for 250 clocks, then send 00 00 00.
   - Expect no bus access and no tx activity.
6. **Reset mid-frame:** pulse `reset` during DATA and during RESP.
   - Expect `tx_out`=1 and `sel_out`=0 the next cycle.
   - A subsequent full write completes normally.
